factorial_scheduler: RTL and testbench

Multi-cycle factorial engine shared between two requesters. A round-robin arbiter accepts one job at a time. The job runs on a single WIDTH-bit iterative multiplier, one multiply per cycle. The result is returned over a valid/ready response channel tagged with the requester ID. The block sits behind the math datapath and is its only path to the factorial function; each compute is serialised instead of being unrolled into a combinational loop.

---
 rtl/factorial_scheduler.sv | 129 ++++++++++++
 tb/tb_factorial_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/factorial_scheduler.sv
// ---------------------------------------------------------------------------
// factorial_scheduler
//   Two-requester factorial engine. A round-robin arbiter accepts one job at
//   a time; the job runs on one WIDTH x WIDTH iterative multiplier (one
//   multiply per cycle, counting n down to 2). The result n! mod 2^WIDTH is
//   returned on a valid/ready response channel, tagged with the requester ID
//   and a sticky overflow flag.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req0_valid/n/ready    requester 0 job channel (ready is combinational)
//   req1_valid/n/ready    requester 1 job channel (ready is combinational)
//   rsp_valid/ready       response handshake
//   rsp_result            n! mod 2^WIDTH
//   rsp_id                requester that issued the job
//   rsp_ovf               some partial product exceeded WIDTH bits
//   busy                  engine not idle
// ---------------------------------------------------------------------------
module factorial_scheduler #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned N_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [N_W-1:0]   req0_n,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [N_W-1:0]   req1_n,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_id,
  output logic             rsp_ovf,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_prio;
  logic [WIDTH-1:0] r_acc;
  logic [N_W-1:0]   r_cnt;
  logic             r_id;
  logic             r_ovf;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_id;
  logic             r_rsp_ovf;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic [PW-1:0]    w_prod;

  // Round-robin grant: a lone requester always wins; on a tie, prio decides.
  assign w_grant0 = req0_valid & (~req1_valid | ~r_prio);
  assign w_grant1 = req1_valid & (~req0_valid |  r_prio);

  assign req0_ready = (r_state == S_IDLE) & w_grant0;
  assign req1_ready = (r_state == S_IDLE) & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  // Full-width product so the upper half can flag overflow.
  assign w_prod = PW'(r_acc) * PW'(r_cnt);

  // Job FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_prio       <= 1'b0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_id         <= 1'b0;
      r_ovf        <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc   <= WIDTH'(1);
            r_cnt   <= w_grant1 ? req1_n : req0_n;
            r_id    <= w_grant1;
            r_ovf   <= 1'b0;
            // Last-granted requester loses priority.
            r_prio  <= ~w_grant1;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt >= N_W'(2)) begin
            r_acc <= w_prod[WIDTH-1:0];
            r_ovf <= r_ovf | (|w_prod[PW-1:WIDTH]);
            r_cnt <= r_cnt - N_W'(1);
          end else begin
            // cnt of 0 or 1 ends the job; covers 0! = 1! = 1.
            r_rsp_result <= r_acc;
            r_rsp_id     <= r_id;
            r_rsp_ovf    <= r_ovf;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign rsp_result = r_rsp_result;
  assign rsp_id     = r_rsp_id;
  assign rsp_ovf    = r_rsp_ovf;

endmodule

// File: tb/tb_factorial_scheduler.sv
// ---------------------------------------------------------------------------
// tb_factorial_scheduler
//   Directed bench for factorial_scheduler: single jobs, 0!/1!, alternating
//   arbitration, overflow boundary, response backpressure and reset during a
//   computation. Inputs are driven and outputs sampled around the falling
//   clock edge.
// ---------------------------------------------------------------------------
module tb_factorial_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [4:0]  req0_n;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_n;
  logic        req1_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_id;
  logic        rsp_ovf;
  logic        busy;

  int n_total;
  int n_bad;

  factorial_scheduler #(.WIDTH(32), .N_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_n     (req0_n),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_n     (req1_n),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id),
    .rsp_ovf    (rsp_ovf),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, report a mismatch.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // n! mod 2^32, multiplied in ascending order.
  function automatic logic [31:0] fact_mod(input int n);
    longint unsigned a;
    a = 64'd1;
    for (int i = 2; i <= n; i++) a = (a * longint'(i)) & 64'hFFFF_FFFF;
    return a[31:0];
  endfunction

  // Wait (bounded) for rsp_valid; lat counts falling edges waited.
  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk({tag, "_timeout"}, 64'(0), 64'(1));
  endtask

  // Complete the response handshake on the next rising edge.
  task automatic pop();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
  endtask

  // Issue one job on a single requester and check the full response.
  task automatic do_job(input string tag, input bit id, input logic [4:0] n,
                        input logic [31:0] exp_res, input bit exp_ovf);
    int k;
    int lat;
    logic rdy;
    if (id) begin req1_valid = 1'b1; req1_n = n; end
    else    begin req0_valid = 1'b1; req0_n = n; end
    #1;
    rdy = id ? req1_ready : req0_ready;
    k = 0;
    while (!rdy && k < 50) begin
      @(negedge clk); #1;
      rdy = id ? req1_ready : req0_ready;
      k++;
    end
    chk({tag, "_ready"}, 64'(rdy), 64'(1));
    @(negedge clk);
    // Still valid, but the engine is no longer idle.
    chk({tag, "_ready_pulse"}, 64'(id ? req1_ready : req0_ready), 64'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(tag, lat);
    chk({tag, "_latency"}, 64'(lat), 64'((n < 5'd2) ? 1 : int'(n)));
    chk({tag, "_result"},  64'(rsp_result), 64'(exp_res));
    chk({tag, "_id"},      64'(rsp_id), 64'(id));
    chk({tag, "_ovf"},     64'(rsp_ovf), 64'(exp_ovf));
    chk({tag, "_busy"},    64'(busy), 64'(1));
    pop();
    chk({tag, "_valid_drop"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_idle"},       64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int errs;
    n_total    = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req0_n     = '0;
    req1_valid = 1'b0;
    req1_n     = '0;
    rsp_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid",  64'(rsp_valid),  64'(0));
    chk("rst_result", 64'(rsp_result), 64'(0));
    chk("rst_id",     64'(rsp_id),     64'(0));
    chk("rst_ovf",    64'(rsp_ovf),    64'(0));
    chk("rst_busy",   64'(busy),       64'(0));
    chk("rst_ready0", 64'(req0_ready), 64'(0));
    chk("rst_ready1", 64'(req1_ready), 64'(0));
    rst_n = 1'b1;

    // Single jobs; the first accept lands on the first edge after reset.
    do_job("n5_r0", 1'b0, 5'd5, 32'd120, 1'b0);
    do_job("n0_r1", 1'b1, 5'd0, 32'd1,   1'b0);
    do_job("n1_r1", 1'b1, 5'd1, 32'd1,   1'b0);

    // Both requesters valid continuously: grants alternate starting with 0.
    req0_n = 5'd3; req1_n = 5'd4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rsp("alt", lat);
      chk($sformatf("alt%0d_id", i),     64'(rsp_id),     64'(i % 2));
      chk($sformatf("alt%0d_result", i), 64'(rsp_result), 64'((i % 2) ? 24 : 6));
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    #1;
    chk("alt_idle", 64'(busy), 64'(0));

    // Overflow boundary
    do_job("n12", 1'b0, 5'd12, 32'd479001600,  1'b0);
    do_job("n13", 1'b1, 5'd13, 32'd1932053504, 1'b1);
    do_job("n31", 1'b0, 5'd31, fact_mod(31),   1'b1);

    // Backpressure: response held while a new request waits.
    req0_valid = 1'b1; req0_n = 5'd2;
    #1;
    chk("bp_acc_ready", 64'(req0_ready), 64'(1));
    @(negedge clk);
    req0_valid = 1'b0;
    wait_rsp("bp", lat);
    req1_valid = 1'b1; req1_n = 5'd3;
    #1;
    chk("bp_req1_blocked", 64'(req1_ready), 64'(0));
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result !== 32'd2 || rsp_id !== 1'b0 ||
          rsp_ovf !== 1'b0 || req1_ready || req0_ready || !busy) errs++;
    end
    chk("bp_stable", 64'(errs), 64'(0));
    pop();
    chk("bp_ready_after_hs", 64'(req1_ready), 64'(1));
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp("bp2", lat);
    chk("bp2_latency", 64'(lat), 64'(3));
    chk("bp2_result",  64'(rsp_result), 64'(6));
    chk("bp2_id",      64'(rsp_id), 64'(1));
    pop();

    // Reset in the middle of an n=20 job.
    req1_valid = 1'b1; req1_n = 5'd20;
    #1;
    chk("rc_ready", 64'(req1_ready), 64'(1));
    @(negedge clk);
    req1_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rc_busy",   64'(busy),       64'(0));
    chk("rc_valid",  64'(rsp_valid),  64'(0));
    chk("rc_result", 64'(rsp_result), 64'(0));
    chk("rc_id",     64'(rsp_id),     64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) errs++;
    end
    chk("rc_no_stale", 64'(errs), 64'(0));
    req0_valid = 1'b1; req0_n = 5'd4;
    req1_valid = 1'b1; req1_n = 5'd4;
    #1;
    chk("rc_grant0", 64'(req0_ready), 64'(1));
    chk("rc_grant1", 64'(req1_ready), 64'(0));
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp("rc_new", lat);
    chk("rc_new_latency", 64'(lat), 64'(4));
    chk("rc_new_result",  64'(rsp_result), 64'(24));
    chk("rc_new_id",      64'(rsp_id), 64'(0));
    chk("rc_new_ovf",     64'(rsp_ovf), 64'(0));
    pop();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
